// File: rtl/cm_sort_ser_if.sv
// Handshake bundle for cm_sort_ser: sorted-vector input side and serial element output side.
// The slave modport is the serializer; the master modport is the surrounding environment.
interface cm_sort_ser_if #(
  parameter int unsigned DCNT   = 4,
  parameter int unsigned DWIDTH = 8
);
  localparam int unsigned IW = $clog2(DCNT);

  logic                   i_vld;
  logic                   o_rdy;
  logic [DCNT*IW-1:0]     i_idx;
  logic [DCNT*DWIDTH-1:0] i_data;
  logic                   o_vld;
  logic                   i_rdy;
  logic [DWIDTH-1:0]      o_data;
  logic [IW-1:0]          o_idx;
  logic [IW-1:0]          o_pos;
  logic                   o_last;

  modport slave (
    input  i_vld, i_idx, i_data, i_rdy,
    output o_rdy, o_vld, o_data, o_idx, o_pos, o_last
  );

  modport master (
    output i_vld, i_idx, i_data, i_rdy,
    input  o_rdy, o_vld, o_data, o_idx, o_pos, o_last
  );
endinterface

// File: rtl/cm_sort_ser.sv
// Serializes a sorted DCNT-element vector into one element per output handshake.
// Define CM_SORT_SER_DESC_EN to emit largest-first; default emission order is ascending.
module cm_sort_ser #(
  parameter int unsigned DCNT   = 4,
  parameter int unsigned DWIDTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  cm_sort_ser_if.slave bus
);
  localparam int unsigned   IW   = $clog2(DCNT);
  localparam logic [IW-1:0] LAST = IW'(DCNT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] data_q [DCNT];
  logic [DWIDTH-1:0] data_d [DCNT];
  logic [IW-1:0]     idx_q  [DCNT];
  logic [IW-1:0]     idx_d  [DCNT];

  logic          vld, rdy, last, in_hs, out_hs;
  logic [IW-1:0] slot;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '{default: '0};
      idx_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          state_d = SEND;
          cnt_d   = '0;
          for (int unsigned k = 0; k < DCNT; k++) begin
            data_d[k] = bus.i_data[k*DWIDTH +: DWIDTH];
            idx_d[k]  = bus.i_idx[k*IW +: IW];
          end
        end
      end
      SEND: begin
        if (out_hs) begin
          if (!last) begin
            cnt_d = cnt_q + IW'(1);
          end else if (in_hs) begin
            cnt_d = '0;
            for (int unsigned k = 0; k < DCNT; k++) begin
              data_d[k] = bus.i_data[k*DWIDTH +: DWIDTH];
              idx_d[k]  = bus.i_idx[k*IW +: IW];
            end
          end else begin
            // Counter is cleared on the way back so o_last stays low while idle.
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef CM_SORT_SER_DESC_EN
    slot = LAST - cnt_q;
`else
    slot = cnt_q;
`endif
    last   = (cnt_q == LAST);
    vld    = (state_q == SEND);
    rdy    = (state_q == IDLE) || (bus.i_rdy && last);
    in_hs  = bus.i_vld && rdy;
    out_hs = vld && bus.i_rdy;
  end

  assign bus.o_vld  = vld;
  assign bus.o_rdy  = rdy;
  assign bus.o_last = last;
  assign bus.o_pos  = cnt_q;
  assign bus.o_data = data_q[slot];
  assign bus.o_idx  = idx_q[slot];
endmodule

// File: tb/tb_cm_sort_ser.sv
// Bench for cm_sort_ser: directed and randomized vectors checked against a queue-based model.
// The model honours CM_SORT_SER_DESC_EN the same way the design does.
module tb_cm_sort_ser;
  localparam int unsigned DCNT = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned IW   = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] ix;
    logic [IW-1:0] pos;
    logic          last;
  } el_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  el_t  pend [$];

  logic [DW-1:0]      cur_d  [DCNT];
  logic [IW-1:0]      cur_ix [DCNT];
  logic [DCNT*DW-1:0] pk_d;
  logic [DCNT*IW-1:0] pk_ix;
  logic               last_accept;
  int                 run, max_run;

  cm_sort_ser_if #(.DCNT(DCNT), .DWIDTH(DW)) bus ();

  cm_sort_ser #(.DCNT(DCNT), .DWIDTH(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_vec();
    for (int k = 0; k < DCNT; k++) begin
      pk_d[k*DW +: DW]  = cur_d[k];
      pk_ix[k*IW +: IW] = cur_ix[k];
    end
  endtask

  // Random ascending data with a random index permutation.
  task automatic rand_vec();
    logic [DW-1:0] q [$];
    logic [IW-1:0] p [$];
    logic [IW-1:0] t;
    int unsigned   j;
    for (int k = 0; k < DCNT; k++) begin
      q.push_back(DW'($urandom));
      p.push_back(IW'(k));
    end
    q.sort();
    for (int k = DCNT - 1; k > 0; k--) begin
      j = $urandom_range(k, 0);
      t = p[k]; p[k] = p[j]; p[j] = t;
    end
    for (int k = 0; k < DCNT; k++) begin
      cur_d[k]  = q[k];
      cur_ix[k] = p[k];
    end
    pack_vec();
  endtask

  task automatic push_vec();
    el_t e;
    int  s;
    for (int p = 0; p < DCNT; p++) begin
`ifdef CM_SORT_SER_DESC_EN
      s = DCNT - 1 - p;
`else
      s = p;
`endif
      e.d    = cur_d[s];
      e.ix   = cur_ix[s];
      e.pos  = IW'(p);
      e.last = (p == DCNT - 1);
      pend.push_back(e);
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, advance model at posedge.
  task automatic cyc(input logic vld, input logic rdy);
    logic exp_vld, exp_rdy, in_hs, out_hs;
    el_t  e;
    bus.i_vld  = vld;
    bus.i_rdy  = rdy;
    bus.i_data = pk_d;
    bus.i_idx  = pk_ix;
    #1;
    exp_vld = (pend.size() > 0);
    exp_rdy = (pend.size() == 0) || (pend.size() == 1 && rdy);
    chk("o_vld", 32'(bus.o_vld), 32'(exp_vld));
    chk("o_rdy", 32'(bus.o_rdy), 32'(exp_rdy));
    if (exp_vld) begin
      e = pend[0];
      chk("o_data", 32'(bus.o_data), 32'(e.d));
      chk("o_idx",  32'(bus.o_idx),  32'(e.ix));
      chk("o_pos",  32'(bus.o_pos),  32'(e.pos));
      chk("o_last", 32'(bus.o_last), 32'(e.last));
    end else begin
      chk("o_last_idle", 32'(bus.o_last), 32'd0);
    end
    run     = (bus.o_vld === 1'b1) ? run + 1 : 0;
    max_run = (run > max_run) ? run : max_run;
    in_hs   = vld && exp_rdy;
    out_hs  = exp_vld && rdy;
    last_accept = in_hs;
    @(posedge clk);
    if (out_hs) void'(pend.pop_front());
    if (in_hs) push_vec();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    pend.delete();
    chk("rst_o_vld",  32'(bus.o_vld),  32'd0);
    chk("rst_o_rdy",  32'(bus.o_rdy),  32'd1);
    chk("rst_o_data", 32'(bus.o_data), 32'd0);
    chk("rst_o_idx",  32'(bus.o_idx),  32'd0);
    chk("rst_o_pos",  32'(bus.o_pos),  32'd0);
    chk("rst_o_last", 32'(bus.o_last), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; run = 0; max_run = 0;
    rst = 1'b1;
    bus.i_vld = 1'b0; bus.i_rdy = 1'b0; bus.i_data = '0; bus.i_idx = '0;
    pk_d = '0; pk_ix = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Reference vector: data slot0..3 = 10,20,30,40, idx slot0..3 = 1,3,0,2.
    cur_d  = '{8'd10, 8'd20, 8'd30, 8'd40};
    cur_ix = '{2'd1, 2'd3, 2'd0, 2'd2};
    pack_vec();
    cyc(1'b1, 1'b1);
    chk("first_accept", 32'(last_accept), 32'd1);
    repeat (6) cyc(1'b0, 1'b1);

    // Back-to-back: second vector must be accepted on the last-element cycle.
    run = 0; max_run = 0;
    rand_vec();
    cyc(1'b1, 1'b1);
    rand_vec();
    for (int n = 0; n < 10; n++) begin
      cyc(1'b1, 1'b1);
      if (last_accept) break;
    end
    chk("b2b_accept", 32'(last_accept), 32'd1);
    repeat (5) cyc(1'b0, 1'b1);
    chk("b2b_run", 32'(max_run), 32'd8);

    // Backpressure at position 1 with a competing input that must be ignored.
    cur_d  = '{8'd10, 8'd20, 8'd30, 8'd40};
    cur_ix = '{2'd1, 2'd3, 2'd0, 2'd2};
    pack_vec();
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    rand_vec();
    repeat (3) begin
      cyc(1'b1, 1'b0);
      chk("bp_no_capture", 32'(last_accept), 32'd0);
    end
    repeat (6) cyc(1'b0, 1'b1);

    // Reset in the middle of a vector, then a fresh vector from position 0.
    rand_vec();
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("pre_rst_pos", 32'(bus.o_pos), 32'd2);
    do_reset();
    rand_vec();
    cyc(1'b1, 1'b1);
    chk("post_rst_accept", 32'(last_accept), 32'd1);
    repeat (6) cyc(1'b0, 1'b1);

    // Randomized traffic.
    rand_vec();
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) != 0));
      if (last_accept) rand_vec();
    end
    repeat (8) cyc(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cm_sort_ser.md
CM_SORT_SER -- requirements
Module: cm_sort_ser

Interface
REQ-001 The module SHALL have parameter DCNT, u32, default 4: number of elements per vector; a power of two, 2 or greater.
REQ-002 The module SHALL have parameter DWIDTH, u32, default 8: element data width in bits.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port i_vld, input, 1 bit: an input vector is present.
REQ-006 Port o_rdy, output, 1 bit: the block can accept an input vector this cycle.
REQ-007 Port i_idx, input, DCNT x $clog2(DCNT) bits: the original index of each sorted element.
REQ-008 Port i_data, input, DCNT x DWIDTH bits: the sorted elements; slot 0 holds the smallest.
REQ-009 Port o_vld, output, 1 bit: an output element is present.
REQ-010 Port i_rdy, input, 1 bit: the downstream stage accepts the output element.
REQ-011 Port o_data, output, DWIDTH bits: the current element.
REQ-012 Port o_idx, output, $clog2(DCNT) bits: the original index of the current element.
REQ-013 Port o_pos, output, $clog2(DCNT) bits: the position of the current element in the emission order, 0 to DCNT-1.
REQ-014 Port o_last, output, 1 bit: the current element is the final element of its vector.

Function
REQ-015 The block SHALL serialize each accepted sorted vector into DCNT elements, emitted one per output handshake.
REQ-016 An input handshake SHALL occur when i_vld and o_rdy are both 1 in the same cycle.
REQ-017 An output handshake SHALL occur when o_vld and i_rdy are both 1 in the same cycle.
REQ-018 The FSM SHALL have two states, IDLE and SEND.
REQ-019 In IDLE: o_rdy=1 and o_vld=0.
REQ-020 In IDLE, an input handshake SHALL capture i_data and i_idx into the holding registers, set the position counter to 0, and move to SEND.
REQ-021 In SEND: o_vld=1; o_data and o_idx SHALL be selected from the holding registers by the slot derived from the position counter; o_pos SHALL equal the counter.
REQ-022 In SEND, o_rdy SHALL be (i_rdy AND o_last); this is a combinational path from i_rdy.
REQ-023 An output handshake with o_last=0 SHALL increment the counter by 1.
REQ-024 An output handshake with o_last=1 and no simultaneous input handshake SHALL return the FSM to IDLE.
REQ-025 An output handshake with o_last=1 and a simultaneous input handshake SHALL load the new vector, reset the counter to 0, and remain in SEND; vectors stream back-to-back with no bubble.
REQ-026 o_last SHALL be 1 exactly when the counter equals DCNT-1.
REQ-027 The counter SHALL NOT wrap past DCNT-1.
REQ-028 Latency SHALL be one cycle: a vector accepted in cycle N presents element 0 in cycle N+1.
REQ-029 While i_rdy=0 in SEND, o_data, o_idx, o_pos and o_last SHALL hold stable and o_vld SHALL stay 1.
REQ-030 Steady-state throughput SHALL be one vector per DCNT cycles.
REQ-031 i_vld while o_rdy=0 SHALL be ignored, and the input SHALL NOT be captured.

Reset
REQ-032 Asserting i_rst SHALL immediately force state=IDLE, counter=0, o_vld=0 and o_rdy=1.
REQ-033 Asserting i_rst SHALL force o_data=0, o_idx=0, o_pos=0 and o_last=0 by clearing the holding registers and counter.
REQ-034 A reset asserted mid-vector SHALL discard the remaining elements.
REQ-035 The first input handshake SHALL be possible on the first rising edge after i_rst deasserts.

Configuration
REQ-036 Macro CM_SORT_SER_DESC_EN SHALL select the emission order.
REQ-037 With CM_SORT_SER_DESC_EN defined, the slot SHALL be DCNT-1-counter: the largest element is emitted first.
REQ-038 With CM_SORT_SER_DESC_EN undefined, the slot SHALL equal the counter: ascending order.
REQ-039 In both configurations, o_pos SHALL be the counter value, not the slot.

Verification
REQ-040 Basic ascending case, DCNT=4, DWIDTH=8, macro undefined: after reset, drive i_data={40,30,20,10} (slot3..0) with i_idx={2,0,3,1} and i_rdy=1. Required: o_data=10,20,30,40 and o_idx=1,3,0,2 in cycles N+1..N+4; o_last=1 only at o_data=40; then o_vld=0.
REQ-041 Back-to-back vectors: hold i_vld=1 and present a second vector; the second vector SHALL be accepted in the o_last cycle. Required: 8 consecutive o_vld=1 cycles and o_pos=0,1,2,3,0,1,2,3.
REQ-042 Backpressure: drop i_rdy to 0 for 3 cycles at o_pos=1. Required: o_data=20 and o_pos=1 held for 4 cycles, o_rdy=0 throughout, and an extra i_vld in that window is not captured.
REQ-043 Descending case, macro defined: repeat the vector from REQ-040. Required: o_data=40,30,20,10, o_idx=2,0,3,1, o_pos=0,1,2,3.
REQ-044 Reset mid-operation: assert i_rst at o_pos=2. Required: o_vld=0 and o_rdy=1 immediately; the next vector is emitted from o_pos=0 with no stale data.
